// File: rtl/rv32i_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I constants and the 2-bit direction counter helper
//               used by the fetch stage and its branch predictor.
// Revision    : 1.0  initial release
// ============================================================================
package rv32i_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  // Direction counter encodings; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating up/down step of a direction counter.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_bpred_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : if_stage_bpred_if
// Description : Bundle of the fetch stage's instruction-memory port, EX
//               resolution/redirect feedback, stall and IF/ID outputs.
// Revision    : 1.0  initial release
// ============================================================================
interface if_stage_bpred_if #(
  parameter int XLEN = rv32i_pkg::XLEN
) ();

  logic            i_stall;
  logic [XLEN-1:0] o_imem_addr;
  logic [31:0]     i_imem_rdata;

  logic            i_ex_valid;
  logic            i_ex_is_cti;
  logic            i_ex_is_jal;
  logic [XLEN-1:0] i_ex_pc;
  logic            i_ex_taken;
  logic [XLEN-1:0] i_ex_target;
  logic            i_ex_redirect;
  logic [XLEN-1:0] i_ex_redirect_pc;

  logic            o_id_valid;
  logic [31:0]     o_id_instr;
  logic [XLEN-1:0] o_id_pc;
  logic            o_id_pred_taken;
  logic [XLEN-1:0] o_id_pred_target;

  // Fetch stage side.
  modport master (
    input  i_stall,
    output o_imem_addr,
    input  i_imem_rdata,
    input  i_ex_valid, i_ex_is_cti, i_ex_is_jal, i_ex_pc, i_ex_taken,
    input  i_ex_target, i_ex_redirect, i_ex_redirect_pc,
    output o_id_valid, o_id_instr, o_id_pc, o_id_pred_taken, o_id_pred_target
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output i_stall,
    input  o_imem_addr,
    output i_imem_rdata,
    output i_ex_valid, i_ex_is_cti, i_ex_is_jal, i_ex_pc, i_ex_taken,
    output i_ex_target, i_ex_redirect, i_ex_redirect_pc,
    input  o_id_valid, o_id_instr, o_id_pc, o_id_pred_taken, o_id_pred_target
  );

endinterface
`default_nettype wire

// File: rtl/if_stage_bpred_btb_bht.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : btb_bht
// Description : Direct-mapped branch target buffer with per-entry 2-bit
//               direction counter and jal flag. Combinational lookup port,
//               one synchronous training port. Lookup never sees a same-cycle
//               update.
// Revision    : 1.0  initial release
// ============================================================================
module btb_bht #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  // lookup
  input  wire logic [XLEN-1:2] i_rd_pc,
  output logic                 o_rd_taken,
  output logic [XLEN-1:0]      o_rd_target,
  // training
  input  wire logic            i_wr_en,
  input  wire logic [XLEN-1:2] i_wr_pc,
  input  wire logic            i_wr_taken,
  input  wire logic [XLEN-1:0] i_wr_target,
  input  wire logic            i_wr_jal
);
  import rv32i_pkg::*;

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic             r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  r_target [BTB_ENTRIES];
  logic [1:0]       r_ctr    [BTB_ENTRIES];
  logic             r_jal    [BTB_ENTRIES];

  logic [IDX-1:0]   w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_hit;
  logic [IDX-1:0]   w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_wr_hit;

  assign w_rd_idx = i_rd_pc[IDX+1:2];
  assign w_rd_tag = i_rd_pc[XLEN-1:IDX+2];
  assign w_wr_idx = i_wr_pc[IDX+1:2];
  assign w_wr_tag = i_wr_pc[XLEN-1:IDX+2];

  // Lookup: a jal entry is always taken, a branch follows its counter MSB.
  always_comb begin
    w_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    o_rd_taken  = w_rd_hit && (r_jal[w_rd_idx] || r_ctr[w_rd_idx][1]);
    o_rd_target = r_target[w_rd_idx];
    w_wr_hit    = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
  end

  // Training: update a hit entry, allocate on a taken miss, ignore a not-taken miss.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= WNT;
        r_jal[i]    <= 1'b0;
      end
    end else if (i_wr_en) begin
      if (w_wr_hit) begin
        r_ctr[w_wr_idx] <= ctr_update(r_ctr[w_wr_idx], i_wr_taken);
        if (i_wr_taken) begin
          r_target[w_wr_idx] <= i_wr_target;
          r_jal[w_wr_idx]    <= i_wr_jal;
        end
      end else if (i_wr_taken) begin
        r_valid[w_wr_idx]  <= 1'b1;
        r_tag[w_wr_idx]    <= w_wr_tag;
        r_target[w_wr_idx] <= i_wr_target;
        r_ctr[w_wr_idx]    <= WT;
        r_jal[w_wr_idx]    <= i_wr_jal;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_stage_bpred.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : if_stage_bpred
// Description : Instruction fetch stage. Holds the PC, predicts the next PC
//               from the BTB, and registers the fetched instruction with its
//               prediction into IF/ID. EX redirects fetch and trains the BTB.
// Revision    : 1.0  initial release
// ============================================================================
module if_stage_bpred #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  if_stage_bpred_if.master   bus
);
  import rv32i_pkg::*;

  localparam logic [XLEN-1:0] C_RESET_PC = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] r_pc;
  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;
  logic            r_id_pred_taken;
  logic [XLEN-1:0] r_id_pred_target;

  logic            w_pred_taken;
  logic [XLEN-1:0] w_btb_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pred_next;
  logic            w_train;
  logic            w_unused_bits;

  btb_bht #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb_bht (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_pc     (r_pc[XLEN-1:2]),
    .o_rd_taken  (w_pred_taken),
    .o_rd_target (w_btb_target),
    .i_wr_en     (w_train),
    .i_wr_pc     (bus.i_ex_pc[XLEN-1:2]),
    .i_wr_taken  (bus.i_ex_taken),
    .i_wr_target (bus.i_ex_target),
    .i_wr_jal    (bus.i_ex_is_jal)
  );

  assign w_train     = bus.i_ex_valid && bus.i_ex_is_cti;
  assign w_pc_plus4  = r_pc + XLEN'(4);
  // Predicted targets are word-aligned so the fetch address never carries low bits.
  assign w_pred_next = w_pred_taken ? {w_btb_target[XLEN-1:2], 2'b00} : w_pc_plus4;

  assign w_unused_bits = ^{w_btb_target[1:0], bus.i_ex_pc[1:0], bus.i_ex_redirect_pc[1:0]};

  assign bus.o_imem_addr      = r_pc;
  assign bus.o_id_valid       = r_id_valid;
  assign bus.o_id_instr       = r_id_instr;
  assign bus.o_id_pc          = r_id_pc;
  assign bus.o_id_pred_taken  = r_id_pred_taken;
  assign bus.o_id_pred_target = r_id_pred_target;

  // PC and IF/ID: redirect beats stall, stall holds, otherwise follow the prediction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc             <= C_RESET_PC;
      r_id_valid       <= 1'b0;
      r_id_instr       <= NOP_INSTR;
      r_id_pc          <= '0;
      r_id_pred_taken  <= 1'b0;
      r_id_pred_target <= '0;
    end else if (bus.i_ex_redirect) begin
      r_pc             <= {bus.i_ex_redirect_pc[XLEN-1:2], 2'b00};
      r_id_valid       <= 1'b0;
      r_id_instr       <= NOP_INSTR;
      r_id_pred_taken  <= 1'b0;
      r_id_pred_target <= '0;
    end else if (!bus.i_stall) begin
      r_pc             <= w_pred_next;
      r_id_valid       <= 1'b1;
      r_id_instr       <= bus.i_imem_rdata;
      r_id_pc          <= r_pc;
      r_id_pred_taken  <= w_pred_taken;
      r_id_pred_target <= w_pred_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage_bpred.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_if_stage_bpred
// Description : Self-checking bench for if_stage_bpred. Stimulus pushes the
//               expected IF/ID contents of each fetch into a queue; a monitor
//               pops and compares whenever IF/ID is loaded.
// Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage_bpred;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  if_stage_bpred_if #(.XLEN(32)) bus ();

  if_stage_bpred #(
    .XLEN        (32),
    .BTB_ENTRIES (16),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign bus.i_imem_rdata = instr_of(bus.o_imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
  } id_t;

  id_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic        mon_load = 1'b0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Remember whether the last edge was a normal IF/ID load.
  always @(posedge clk) mon_load <= rst_n && !bus.i_stall && !bus.i_ex_redirect;

  // Scoreboard monitor: every loaded IF/ID must match the next expected fetch.
  always @(negedge clk) begin
    id_t got;
    id_t want;
    if (mon_load) begin
      checks++;
      got = {bus.o_id_pc, bus.o_id_instr, bus.o_id_pred_taken, bus.o_id_pred_target};
      if (!bus.o_id_valid) begin
        errors++;
        $display("FAIL id_valid: got 0 want 1 (pc %h)", bus.o_id_pc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL id_unexpected: got pc %h, no fetch expected", bus.o_id_pc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL id_out: got pc=%h instr=%h pt=%b tgt=%h want pc=%h instr=%h pt=%b tgt=%h",
                   got.pc, got.instr, got.taken, got.target,
                   want.pc, want.instr, want.taken, want.target);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One normal fetch at exp_pc with the hand-computed prediction.
  task automatic fetch(input logic tk, input logic [31:0] nxt);
    check32("imem_addr", bus.o_imem_addr, exp_pc);
    exp_q.push_back({exp_pc, instr_of(exp_pc), tk, nxt});
    step();
    exp_pc = nxt;
  endtask

  task automatic redirect(input logic [31:0] rpc, input logic stall, input logic [31:0] want_pc);
    bus.i_ex_redirect    = 1'b1;
    bus.i_ex_redirect_pc = rpc;
    bus.i_stall          = stall;
    step();
    bus.i_ex_redirect = 1'b0;
    bus.i_stall       = 1'b0;
    exp_pc            = want_pc;
    check32("redirect_pc", bus.o_imem_addr, want_pc);
    check32("bubble_valid", 32'(bus.o_id_valid), 32'd0);
    check32("bubble_instr", bus.o_id_instr, 32'h0000_0013);
    check32("bubble_pred", 32'(bus.o_id_pred_taken), 32'd0);
  endtask

  // Resolve one control transfer in EX while fetch is stalled.
  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic jal);
    bus.i_stall     = 1'b1;
    bus.i_ex_valid  = 1'b1;
    bus.i_ex_is_cti = 1'b1;
    bus.i_ex_is_jal = jal;
    bus.i_ex_pc     = pc;
    bus.i_ex_taken  = tk;
    bus.i_ex_target = tgt;
    step();
    bus.i_stall    = 1'b0;
    bus.i_ex_valid = 1'b0;
    bus.i_ex_is_cti = 1'b0;
    check32("stall_hold", bus.o_imem_addr, exp_pc);
  endtask

  initial begin
    bus.i_stall          = 1'b0;
    bus.i_ex_valid       = 1'b0;
    bus.i_ex_is_cti      = 1'b0;
    bus.i_ex_is_jal      = 1'b0;
    bus.i_ex_pc          = '0;
    bus.i_ex_taken       = 1'b0;
    bus.i_ex_target      = '0;
    bus.i_ex_redirect    = 1'b0;
    bus.i_ex_redirect_pc = '0;
    exp_pc               = 32'h0;

    // Reset state
    repeat (2) step();
    check32("rst_imem_addr", bus.o_imem_addr, 32'h0);
    check32("rst_id_valid", 32'(bus.o_id_valid), 32'd0);
    check32("rst_id_instr", bus.o_id_instr, 32'h0000_0013);
    check32("rst_id_pc", bus.o_id_pc, 32'h0);
    check32("rst_pred_taken", 32'(bus.o_id_pred_taken), 32'd0);
    check32("rst_pred_target", bus.o_id_pred_target, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch
    fetch(1'b0, 32'h04);
    fetch(1'b0, 32'h08);
    fetch(1'b0, 32'h0C);
    fetch(1'b0, 32'h10);

    // Branch 0x10 -> 0x40 resolved while 0x10 is fetched: lookup sees the old (empty) entry
    bus.i_ex_valid  = 1'b1;
    bus.i_ex_is_cti = 1'b1;
    bus.i_ex_is_jal = 1'b0;
    bus.i_ex_pc     = 32'h10;
    bus.i_ex_taken  = 1'b1;
    bus.i_ex_target = 32'h40;
    fetch(1'b0, 32'h14);
    bus.i_ex_valid  = 1'b0;
    bus.i_ex_is_cti = 1'b0;

    // Counter 10: predicted taken, no bubble between 0x10 and 0x40
    redirect(32'h10, 1'b0, 32'h10);
    fetch(1'b1, 32'h40);
    fetch(1'b0, 32'h44);

    // Not-taken three times: 10 -> 01 -> 00 -> 00
    train(32'h10, 1'b0, 32'h0, 1'b0);
    train(32'h10, 1'b0, 32'h0, 1'b0);
    train(32'h10, 1'b0, 32'h0, 1'b0);
    redirect(32'h10, 1'b0, 32'h10);
    fetch(1'b0, 32'h14);

    // Taken once: 00 -> 01, still not taken
    train(32'h10, 1'b1, 32'h40, 1'b0);
    redirect(32'h10, 1'b0, 32'h10);
    fetch(1'b0, 32'h14);

    // Taken again: 01 -> 10, predicted taken
    train(32'h10, 1'b1, 32'h40, 1'b0);
    redirect(32'h10, 1'b0, 32'h10);
    fetch(1'b1, 32'h40);

    // Upper saturation: 10 -> 11 -> 11, then not-taken -> 10 (still taken)
    train(32'h10, 1'b1, 32'h40, 1'b0);
    train(32'h10, 1'b1, 32'h40, 1'b0);
    train(32'h10, 1'b0, 32'h0, 1'b0);
    redirect(32'h10, 1'b0, 32'h10);
    fetch(1'b1, 32'h40);

    // Redirect together with stall, unaligned redirect target
    redirect(32'h83, 1'b1, 32'h80);
    fetch(1'b0, 32'h84);

    // jal 0x20 -> 0x100, counter driven to 00 yet still predicted taken
    train(32'h20, 1'b1, 32'h100, 1'b1);
    train(32'h20, 1'b0, 32'h0, 1'b0);
    train(32'h20, 1'b0, 32'h0, 1'b0);
    redirect(32'h20, 1'b0, 32'h20);
    fetch(1'b1, 32'h100);
    fetch(1'b0, 32'h104);

    // Aliasing PC 0x60 replaces the 0x20 entry
    train(32'h60, 1'b1, 32'h200, 1'b0);
    redirect(32'h20, 1'b0, 32'h20);
    fetch(1'b0, 32'h24);
    redirect(32'h60, 1'b0, 32'h60);
    fetch(1'b1, 32'h200);
    fetch(1'b0, 32'h204);

    // PC+4 wraps at the top of the address space
    redirect(32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
    fetch(1'b0, 32'h0);
    fetch(1'b0, 32'h4);

    // Asynchronous reset mid-operation discards PC, IF/ID and BTB
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check32("arst_imem_addr", bus.o_imem_addr, 32'h0);
    check32("arst_id_valid", 32'(bus.o_id_valid), 32'd0);
    check32("arst_id_instr", bus.o_id_instr, 32'h0000_0013);
    step();
    rst_n  = 1'b1;
    exp_pc = 32'h0;
    fetch(1'b0, 32'h04);
    fetch(1'b0, 32'h08);
    fetch(1'b0, 32'h0C);
    fetch(1'b0, 32'h10);
    fetch(1'b0, 32'h14);

    @(negedge clk);
    #1;
    check32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
